// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting a shared bus to one of four active-low requesters.
// Latency: grant registered one edge after request; one dead cycle between owners.
// Backpressure: owner holds until it drops req_ or is preempted after MAX_HOLD cycles.
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic [3:0] m_req_,
    output logic [3:0] m_grnt_,
    output logic [1:0] owner,
    output logic       bus_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] grnt_q, grnt_d;

    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       others_req;
    logic       own_drop;
    logic       preempt;

    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (!m_req_[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        others_req = |(~m_req_ & ~(4'b0001 << owner_q));
        own_drop   = m_req_[owner_q];
        preempt    = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LIM) && others_req;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        grnt_d     = grnt_q;
        case (state_q)
            IDLE, RELEASE: begin
                if (found) begin
                    state_d    = OWN;
                    owner_d    = win;
                    grnt_d     = ~(4'b0001 << win);
                    hold_cnt_d = 8'd0;
                end else begin
                    state_d = IDLE;
                    grnt_d  = 4'b1111;
                end
            end
            OWN: begin
                if (own_drop || preempt) begin
                    state_d = RELEASE;
                    grnt_d  = 4'b1111;
                    ptr_d   = owner_q + 2'd1;
                end else if (hold_cnt_q != 8'hff) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grnt_d  = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            owner_q    <= 2'd0;
            hold_cnt_q <= 8'd0;
            grnt_q     <= 4'b1111;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            grnt_q     <= grnt_d;
        end
    end

    assign m_grnt_  = grnt_q;
    assign owner    = owner_q;
    assign bus_busy = (state_q == OWN);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a tenure-based reference model.
module tb_bus_arbiter;

    localparam int TB_MAX = 4;

    logic       clk;
    logic       reset_;
    logic [3:0] req_a, req_b;
    logic [3:0] grnt_a, grnt_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who holds the bus, for how many cycles, and where the scan starts.
    int m_owner;
    bit m_busy;
    int m_ptr;
    int m_tenure;

    bus_arbiter #(.MAX_HOLD(TB_MAX)) dut (
        .clk(clk), .reset_(reset_), .m_req_(req_a),
        .m_grnt_(grnt_a), .owner(owner_a), .bus_busy(busy_a)
    );

    bus_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .reset_(reset_), .m_req_(req_b),
        .m_grnt_(grnt_b), .owner(owner_b), .bus_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_busy   = 0;
        m_ptr    = 0;
        m_tenure = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit others;
        if (m_busy) begin
            m_tenure++;
            others = 0;
            for (int i = 0; i < 4; i++)
                if (i != m_owner && r[i] == 1'b0) others = 1;
            if (r[m_owner] == 1'b1 || (TB_MAX != 0 && others && m_tenure >= TB_MAX)) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 4;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && r[(m_ptr + k) % 4] == 1'b0) begin
                    m_owner  = (m_ptr + k) % 4;
                    m_busy   = 1;
                    m_tenure = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [3:0] exp_g;
        logic       one_ok;
        @(posedge clk);
        model_step(req_a);
        @(negedge clk);
        exp_g  = m_busy ? ~(4'b0001 << m_owner) : 4'b1111;
        one_ok = (grnt_a == 4'b1111) || ($countones(~grnt_a) == 1);
        chk("onehot", {31'd0, one_ok}, 32'd1);
        chk("model_grnt", {28'd0, grnt_a}, {28'd0, exp_g});
        chk("model_busy", {31'd0, busy_a}, {31'd0, m_busy});
        chk("model_owner", {30'd0, owner_a}, 32'(m_owner));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        req_a  = 4'b1111;
        req_b  = 4'b1111;
        model_reset();
        #2;
        chk("rst_grnt", {28'd0, grnt_a}, 32'hf);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        reset_ = 1'b0;
        req_a  = 4'b1111;
        req_b  = 4'b1111;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_grnt", {28'd0, grnt_a}, 32'hf);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_owner", {30'd0, owner_a}, 32'd0);
        reset_ = 1'b1;

        // Single request from master 0: one edge to grant.
        req_a = 4'b1110;
        chk("pre_edge_grnt", {28'd0, grnt_a}, 32'hf);
        tick();
        chk("m0_grnt", {28'd0, grnt_a}, 32'he);
        chk("m0_owner", {30'd0, owner_a}, 32'd0);
        chk("m0_busy", {31'd0, busy_a}, 32'd1);
        req_a = 4'b1111;
        tick();
        tick();

        // All masters requesting with MAX_HOLD=4: 4-cycle tenures separated by a dead cycle.
        do_reset();
        req_a = 4'b0000;
        for (int c = 0; c < 25; c++) begin
            tick();
            exp_g = (c % 5 == 4) ? 4'b1111 : ~(4'b0001 << ((c / 5) % 4));
            chk("rr_seq", {28'd0, grnt_a}, {28'd0, exp_g});
        end
        req_a = 4'b1111;
        tick();
        tick();

        // Owner m2 releases on the same edge m1 asks.
        do_reset();
        req_a = 4'b1011;
        tick();
        chk("m2_grnt", {28'd0, grnt_a}, 32'hb);
        repeat (3) tick();
        req_a = 4'b1101;
        tick();
        chk("rel_grnt", {28'd0, grnt_a}, 32'hf);
        chk("rel_busy", {31'd0, busy_a}, 32'd0);
        chk("rel_ptr", {30'd0, dut.ptr_q}, 32'd3);
        tick();
        chk("m1_after_rel", {28'd0, grnt_a}, 32'hd);
        chk("m1_owner", {30'd0, owner_a}, 32'd1);
        req_a = 4'b1111;
        tick();
        tick();

        // Asynchronous reset mid-tenure with a stale ptr of 2.
        do_reset();
        req_a = 4'b1101;
        tick();
        req_a = 4'b1111;
        tick();
        tick();
        req_a = 4'b0111;
        tick();
        chk("m3_grnt", {28'd0, grnt_a}, 32'h7);
        @(posedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        chk("async_grnt", {28'd0, grnt_a}, 32'hf);
        chk("async_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        req_a = 4'b0101;
        tick();
        chk("post_rst_m1", {28'd0, grnt_a}, 32'hd);
        req_a = 4'b1111;
        tick();
        tick();

        // MAX_HOLD=0 instance: lone m3 keeps the bus and the hold counter saturates.
        req_b = 4'b0111;
        tick();
        for (int c = 0; c < 300; c++) begin
            tick();
            chk("nohold_grnt", {28'd0, grnt_b}, 32'h7);
            chk("nohold_busy", {31'd0, busy_b}, 32'd1);
        end
        chk("hold_sat", {24'd0, dut0.hold_cnt_q}, 32'd255);
        req_b = 4'b1111;

        // Random request traffic compared cycle by cycle against the model.
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
